// File: rtl/updi_instruction_arbiter.sv
// Round-robin arbiter that shares one UPDI instruction queue handler between
// N_REQ requesters, snapshots the winning request and runs an ACK watchdog.
module updi_instruction_arbiter #(
  parameter int N_REQ            = 3,
  parameter int MAX_DATA_SIZE    = 16,
  parameter int DATA_ADDR_BITS   = $clog2(MAX_DATA_SIZE),
  parameter int ACK_TIMEOUT_CLKS = 100000,
  parameter int ABORT_CLKS       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_REQ-1:0]                        req,
  input  logic [N_REQ*8-1:0]                      req_opcode,
  input  logic [N_REQ*MAX_DATA_SIZE*8-1:0]        req_data,
  input  logic [N_REQ*(DATA_ADDR_BITS+1)-1:0]     req_data_len,
  input  logic [N_REQ*MAX_DATA_SIZE-1:0]          req_wait_ack_after,
  output logic [N_REQ-1:0]                        grant,
  output logic [N_REQ-1:0]                        req_done,
  output logic [N_REQ-1:0]                        req_error,
  output logic                                    busy,
  output logic                                    handler_start,
  input  logic                                    handler_ready,
  input  logic                                    handler_done,
  input  logic                                    handler_waiting_for_ack,
  output logic                                    handler_abort,
  output logic [7:0]                              hdl_opcode,
  output logic [MAX_DATA_SIZE*8-1:0]              hdl_data,
  output logic [DATA_ADDR_BITS:0]                 hdl_data_len,
  output logic [MAX_DATA_SIZE-1:0]                hdl_wait_ack_after
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int CW     = IDX_W + 1;
  localparam int LEN_W  = DATA_ADDR_BITS + 1;
  localparam int DATA_W = MAX_DATA_SIZE * 8;
  localparam int CNT_W  = $clog2(ACK_TIMEOUT_CLKS + 1);
  localparam int ABT_W  = $clog2(ABORT_CLKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_ABORT
  } state_t;

  state_t state, state_d;

  logic [N_REQ-1:0]  grant_d, done_d, err_d;
  logic              start_d, abort_d;
  logic [7:0]        opc_d;
  logic [DATA_W-1:0] data_d;
  logic [LEN_W-1:0]  len_d;
  logic [MAX_DATA_SIZE-1:0] mask_d;
  logic [IDX_W-1:0]  last_grant, last_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ABT_W-1:0]  abt_cnt, abt_d;

  logic [7:0]               opc_arr  [N_REQ];
  logic [DATA_W-1:0]        data_arr [N_REQ];
  logic [LEN_W-1:0]         len_arr  [N_REQ];
  logic [MAX_DATA_SIZE-1:0] mask_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign opc_arr[g]  = req_opcode[g*8 +: 8];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    assign len_arr[g]  = req_data_len[g*LEN_W +: LEN_W];
    assign mask_arr[g] = req_wait_ack_after[g*MAX_DATA_SIZE +: MAX_DATA_SIZE];
  end

  // Round-robin scan starting just after the previous winner.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [CW-1:0]    cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    state_d = state;
    grant_d = grant;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    abort_d = handler_abort;
    opc_d   = hdl_opcode;
    data_d  = hdl_data;
    len_d   = hdl_data_len;
    mask_d  = hdl_wait_ack_after;
    last_d  = last_grant;
    win_d   = win_q;
    cnt_d   = cnt;
    abt_d   = abt_cnt;

    case (state)
      S_IDLE: begin
        if (handler_ready && !handler_abort && win_found) begin
          grant_d = N_REQ'(1) << win_idx;
          win_d   = win_idx;
          opc_d   = opc_arr[win_idx];
          data_d  = data_arr[win_idx];
          len_d   = len_arr[win_idx];
          mask_d  = mask_arr[win_idx];
          state_d = S_START;
        end
      end

      S_START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_BUSY;
      end

      S_BUSY: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (handler_done) begin
          done_d  = N_REQ'(1) << win_q;
          grant_d = '0;
          last_d  = win_q;
          state_d = S_IDLE;
        end else if (handler_waiting_for_ack) begin
          if (cnt == CNT_W'(ACK_TIMEOUT_CLKS - 1)) begin
            err_d   = N_REQ'(1) << win_q;
            abort_d = 1'b1;
            abt_d   = '0;
            grant_d = '0;
            last_d  = win_q;
            state_d = S_ABORT;
          end else if (cnt != '1) begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      S_ABORT: begin
        if (abt_cnt == ABT_W'(ABORT_CLKS - 1)) begin
          abort_d = 1'b0;
          abt_d   = '0;
          state_d = S_IDLE;
        end else begin
          abt_d = abt_cnt + ABT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      grant              <= '0;
      req_done           <= '0;
      req_error          <= '0;
      handler_start      <= 1'b0;
      handler_abort      <= 1'b0;
      hdl_opcode         <= '0;
      hdl_data           <= '0;
      hdl_data_len       <= '0;
      hdl_wait_ack_after <= '0;
      last_grant         <= IDX_W'(N_REQ - 1);
      win_q              <= '0;
      cnt                <= '0;
      abt_cnt            <= '0;
    end else begin
      state              <= state_d;
      grant              <= grant_d;
      req_done           <= done_d;
      req_error          <= err_d;
      handler_start      <= start_d;
      handler_abort      <= abort_d;
      hdl_opcode         <= opc_d;
      hdl_data           <= data_d;
      hdl_data_len       <= len_d;
      hdl_wait_ack_after <= mask_d;
      last_grant         <= last_d;
      win_q              <= win_d;
      cnt                <= cnt_d;
      abt_cnt            <= abt_d;
    end
  end

endmodule

// File: tb/tb_updi_instruction_arbiter.sv
// Directed self-checking bench for updi_instruction_arbiter (3 requesters,
// 20-cycle ACK watchdog); inputs change and outputs are sampled on negedges.
module tb_updi_instruction_arbiter;

  localparam int N_REQ = 3;
  localparam int MDS   = 16;
  localparam int DAB   = 4;
  localparam int LEN_W = DAB + 1;
  localparam int T_ACK = 20;
  localparam int AB    = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*8-1:0]     req_opcode;
  logic [N_REQ*MDS*8-1:0] req_data;
  logic [N_REQ*LEN_W-1:0] req_data_len;
  logic [N_REQ*MDS-1:0]   req_wait_ack_after;
  logic [N_REQ-1:0]       grant, req_done, req_error;
  logic                   busy, handler_start, handler_abort;
  logic                   handler_ready, handler_done, handler_waiting_for_ack;
  logic [7:0]             hdl_opcode;
  logic [MDS*8-1:0]       hdl_data;
  logic [LEN_W-1:0]       hdl_data_len;
  logic [MDS-1:0]         hdl_wait_ack_after;

  always #5 clk = ~clk;

  updi_instruction_arbiter #(
    .N_REQ(N_REQ),
    .MAX_DATA_SIZE(MDS),
    .DATA_ADDR_BITS(DAB),
    .ACK_TIMEOUT_CLKS(T_ACK),
    .ABORT_CLKS(AB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_opcode(req_opcode),
    .req_data(req_data),
    .req_data_len(req_data_len),
    .req_wait_ack_after(req_wait_ack_after),
    .grant(grant),
    .req_done(req_done),
    .req_error(req_error),
    .busy(busy),
    .handler_start(handler_start),
    .handler_ready(handler_ready),
    .handler_done(handler_done),
    .handler_waiting_for_ack(handler_waiting_for_ack),
    .handler_abort(handler_abort),
    .hdl_opcode(hdl_opcode),
    .hdl_data(hdl_data),
    .hdl_data_len(hdl_data_len),
    .hdl_wait_ack_after(hdl_wait_ack_after)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_req(input int i, input logic [7:0] opc, input logic [LEN_W-1:0] len,
                          input logic [MDS-1:0] mask, input logic [7:0] b0, input logic [7:0] b15);
    req_opcode[i*8 +: 8]           = opc;
    req_data_len[i*LEN_W +: LEN_W] = len;
    req_wait_ack_after[i*MDS +: MDS] = mask;
    req_data[(i*MDS)*8 +: 8]       = b0;
    req_data[(i*MDS+15)*8 +: 8]    = b15;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    handler_done = 1'b0;
    handler_waiting_for_ack = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the start pulse, then completes the transaction.
  task automatic finish_txn(input string tag, input logic [N_REQ-1:0] exp);
    int i;
    i = 0;
    while (handler_start !== 1'b1 && i < 10) begin
      step();
      i++;
    end
    check({tag, "_start"}, handler_start, 1);
    step();
    check({tag, "_start_once"}, handler_start, 0);
    handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    check({tag, "_done"}, req_done, exp);
    check({tag, "_grant_clr"}, grant, 0);
    check({tag, "_busy_low"}, busy, 0);
    step();
    check({tag, "_done_pulse"}, req_done, 0);
  endtask

  logic [N_REQ-1:0] rr_exp [4];
  int i, starts, bad, errs, aborts, dones;

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    req = '0;
    req_opcode = '0;
    req_data = '0;
    req_data_len = '0;
    req_wait_ack_after = '0;
    handler_ready = 1'b1;
    handler_done = 1'b0;
    handler_waiting_for_ack = 1'b0;
    do_reset();

    // Reset state
    check("rst_grant", grant, 0);
    check("rst_done", req_done, 0);
    check("rst_error", req_error, 0);
    check("rst_busy", busy, 0);
    check("rst_start", handler_start, 0);
    check("rst_abort", handler_abort, 0);
    check("rst_opcode", hdl_opcode, 0);
    check("rst_data", hdl_data, 0);
    check("rst_len", hdl_data_len, 0);
    check("rst_mask", hdl_wait_ack_after, 0);

    // Single request from requester 1
    load_req(1, 8'h44, 5'd1, 16'h0001, 8'hA5, 8'h00);
    req = 3'b010;
    step();
    check("single_grant", grant, 3'b010);
    check("single_start_early", handler_start, 0);
    check("single_busy", busy, 1);
    check("single_opcode", hdl_opcode, 8'h44);
    check("single_len", hdl_data_len, 1);
    check("single_data", hdl_data, {120'h0, 8'hA5});
    check("single_mask", hdl_wait_ack_after, 16'h0001);
    req = '0;
    step();
    check("single_start", handler_start, 1);
    step();
    check("single_start_off", handler_start, 0);
    check("single_grant_hold", grant, 3'b010);
    handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    check("single_done", req_done, 3'b010);
    check("single_grant_clr", grant, 0);
    check("single_busy_low", busy, 0);
    step();
    check("single_done_pulse", req_done, 0);
    check("single_opcode_hold", hdl_opcode, 8'h44);

    // Round-robin with all three requesting
    do_reset();
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      i = 0;
      while (handler_start !== 1'b1 && i < 20) begin
        step();
        i++;
      end
      check("rr_start_seen", handler_start, 1);
      check("rr_grant", grant, rr_exp[t]);
      starts = 0;
      bad = 0;
      for (int k = 0; k < 9; k++) begin
        step();
        if (handler_start) starts++;
        if (grant !== rr_exp[t]) bad++;
      end
      check("rr_extra_start", starts, 0);
      check("rr_grant_stable", bad, 0);
      handler_done = 1'b1;
      if (t == 3) req = '0;
      step();
      handler_done = 1'b0;
      check("rr_done", req_done, rr_exp[t]);
    end

    // ACK timeout: last winner 0, so requester 1 wins, then requester 0
    load_req(0, 8'h10, 5'd2, 16'h0002, 8'h01, 8'h0F);
    load_req(1, 8'h21, 5'd3, 16'h0004, 8'h02, 8'h1F);
    req = 3'b011;
    step();
    check("to_grant", grant, 3'b010);
    step();
    check("to_start", handler_start, 1);
    handler_waiting_for_ack = 1'b1;
    errs = 0;
    repeat (19) begin
      step();
      if (req_error != 0) errs++;
    end
    check("to_no_early_error", errs, 0);
    step();
    check("to_error", req_error, 3'b010);
    check("to_abort_on", handler_abort, 1);
    check("to_grant_clr", grant, 0);
    check("to_no_done", req_done, 0);
    handler_waiting_for_ack = 1'b0;
    aborts = 1;
    errs = 0;
    dones = 0;
    repeat (5) begin
      step();
      if (handler_abort) aborts++;
      if (req_error != 0) errs++;
      if (req_done != 0) dones++;
    end
    check("to_abort_len", aborts, AB);
    check("to_error_once", errs, 0);
    check("to_no_done_abort", dones, 0);
    check("to_next_grant", grant, 3'b001);
    check("to_next_opcode", hdl_opcode, 8'h10);
    req = '0;
    finish_txn("to_next", 3'b001);

    // Waiting pulses below threshold: requester 2 wins
    load_req(2, 8'h32, 5'd4, 16'h0008, 8'h03, 8'h2F);
    req = 3'b100;
    step();
    check("wp_grant", grant, 3'b100);
    req = '0;
    step();
    check("wp_start", handler_start, 1);
    errs = 0;
    handler_waiting_for_ack = 1'b1;
    repeat (15) begin
      step();
      if (req_error != 0 || handler_abort) errs++;
    end
    handler_waiting_for_ack = 1'b0;
    step();
    handler_waiting_for_ack = 1'b1;
    repeat (15) begin
      step();
      if (req_error != 0 || handler_abort) errs++;
    end
    handler_waiting_for_ack = 1'b0;
    check("wp_no_error", errs, 0);
    check("wp_grant_hold", grant, 3'b100);
    handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    check("wp_done", req_done, 3'b100);
    check("wp_busy_low", busy, 0);

    // Done and timeout threshold in the same cycle
    req = 3'b001;
    step();
    check("co_grant", grant, 3'b001);
    req = '0;
    step();
    check("co_start", handler_start, 1);
    handler_waiting_for_ack = 1'b1;
    errs = 0;
    repeat (19) begin
      step();
      if (req_error != 0 || handler_abort) errs++;
    end
    handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    handler_waiting_for_ack = 1'b0;
    check("co_no_early", errs, 0);
    check("co_done", req_done, 3'b001);
    check("co_error", req_error, 0);
    check("co_abort", handler_abort, 0);
    check("co_busy_low", busy, 0);
    step();
    check("co_error_late", req_error, 0);
    check("co_abort_late", handler_abort, 0);

    // Reset while busy
    req = 3'b011;
    step();
    check("rb_grant", grant, 3'b010);
    req = '0;
    step();
    check("rb_start", handler_start, 1);
    handler_waiting_for_ack = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    handler_waiting_for_ack = 1'b0;
    check("rb_grant_clr", grant, 0);
    check("rb_busy", busy, 0);
    check("rb_opcode", hdl_opcode, 0);
    check("rb_data", hdl_data, 0);
    check("rb_len", hdl_data_len, 0);
    check("rb_mask", hdl_wait_ack_after, 0);
    check("rb_done", req_done, 0);
    check("rb_error", req_error, 0);
    rst = 1'b0;
    step();
    check("rb_done_after", req_done, 0);
    check("rb_error_after", req_error, 0);
    check("rb_abort_after", handler_abort, 0);

    // Handler not ready holds off arbitration, then requester 2 with len 0
    load_req(2, 8'h5A, 5'd0, 16'h8001, 8'h11, 8'hEE);
    handler_ready = 1'b0;
    req = 3'b100;
    bad = 0;
    repeat (3) begin
      step();
      if (busy || grant != 0) bad++;
    end
    check("nr_hold", bad, 0);
    handler_ready = 1'b1;
    step();
    check("nr_grant", grant, 3'b100);
    check("nr_opcode", hdl_opcode, 8'h5A);
    check("nr_len0", hdl_data_len, 0);
    check("nr_data", hdl_data, {8'hEE, 112'h0, 8'h11});
    check("nr_mask", hdl_wait_ack_after, 16'h8001);
    req = '0;
    finish_txn("nr", 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
